data_sram_responder: RTL and testbench

//  Memory-side responder for the CPU's sram-like data interface (req/addr_ok/data_ok).

---
 rtl/data_sram_responder.sv | 114 +++++++++++
 tb/tb_data_sram_responder.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/data_sram_responder.sv
// data_sram_responder: sram-like data-port responder with programmable latency and byte-lane RAM.
// One request in flight; a handshake while responding starts the next request with no bubble.
module data_sram_responder #(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    input  logic        wr_i,
    input  logic [1:0]  size_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        addr_ok_o,
    output logic        data_ok_o,
    output logic [31:0] rdata_o,
    output logic        err_o
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam logic [3:0] LAT_M1 = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              wr_q, err_q;
    logic [1:0]        size_q;
    logic [ADDR_W+1:0] addr_q;
    logic [31:0]       wdata_q, rdata_q;
    logic [31:0]       mem [2**ADDR_W];

    logic              hs, enter_resp, use_q;
    logic              op_wr, op_err;
    logic [1:0]        op_size;
    logic [ADDR_W+1:0] op_addr;
    logic [31:0]       op_wdata;
    logic [3:0]        op_be;
    logic              unused_hi;

    function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] a);
        return (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a != 2'd0);
    endfunction

    function automatic logic [3:0] byte_en(input logic [1:0] sz, input logic [1:0] a);
        return (sz == 2'd0) ? 4'b0001 << a :
               (sz == 2'd1) ? (a[1] ? 4'b1100 : 4'b0011) :
               (sz == 2'd2) ? 4'b1111 : 4'b0000;
    endfunction

    assign unused_hi = ^addr_i[31:ADDR_W+2];
    assign addr_ok_o = (state_q != WAIT);
    assign hs        = req_i & addr_ok_o;
    assign data_ok_o = (state_q == RESP);
    assign err_o     = data_ok_o & err_q;
    assign rdata_o   = rdata_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE, RESP: begin
                state_d = hs ? ((LATENCY > 0) ? WAIT : RESP) : IDLE;
                cnt_d   = hs ? LAT_M1 : 4'd0;
            end
            WAIT: begin
                state_d = (cnt_q == 4'd0) ? RESP : WAIT;
                cnt_d   = (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    // A zero-latency request reaches RESP on its own handshake edge, so it acts on the live inputs.
    assign use_q      = (state_q == WAIT);
    assign enter_resp = (state_d == RESP);
    assign op_wr      = use_q ? wr_q    : wr_i;
    assign op_size    = use_q ? size_q  : size_i;
    assign op_addr    = use_q ? addr_q  : addr_i[ADDR_W+1:0];
    assign op_wdata   = use_q ? wdata_q : wdata_i;
    assign op_err     = misaligned(op_size, op_addr[1:0]);
    assign op_be      = byte_en(op_size, op_addr[1:0]);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            wr_q    <= 1'b0;
            size_q  <= 2'd0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            err_q   <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (hs) begin
                wr_q    <= wr_i;
                size_q  <= size_i;
                addr_q  <= addr_i[ADDR_W+1:0];
                wdata_q <= wdata_i;
                err_q   <= misaligned(size_i, addr_i[1:0]);
            end
            if (enter_resp && !op_wr)
                rdata_q <= op_err ? 32'd0 : mem[op_addr[ADDR_W+1:2]];
        end
    end

    // RAM is not reset; rst_ni gating keeps a write dropped when reset lands on its commit edge.
    always_ff @(posedge clk_i) begin
        if (rst_ni && enter_resp && op_wr && !op_err)
            for (int i = 0; i < 4; i++)
                if (op_be[i])
                    mem[op_addr[ADDR_W+1:2]][8*i +: 8] <= op_wdata[8*i +: 8];
    end
endmodule

// File: tb/tb_data_sram_responder.sv
// tb_data_sram_responder: table-driven vectors plus scoreboard for LATENCY=2 and LATENCY=0 instances.
module tb_data_sram_responder;
    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rd;
        logic        err;
        logic        chk;
    } vec_t;

    typedef struct {
        logic [31:0] rd;
        logic        err;
        logic        chk;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_a = 1'b0, wr_a = 1'b0, req_b = 1'b0, wr_b = 1'b0;
    logic [1:0]  size_a = 2'd0, size_b = 2'd0;
    logic [31:0] addr_a = 32'd0, wdata_a = 32'd0, addr_b = 32'd0, wdata_b = 32'd0;
    logic        aok_a, dok_a, err_a, aok_b, dok_b, err_b;
    logic [31:0] rd_a, rd_b;

    int   total = 0;
    int   bad = 0;
    exp_t qa[$];
    exp_t qb[$];
    vec_t tbl[16];

    always #5 clk = ~clk;

    data_sram_responder #(.ADDR_W(10), .LATENCY(2)) u_a (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req_a), .wr_i(wr_a), .size_i(size_a),
        .addr_i(addr_a), .wdata_i(wdata_a), .addr_ok_o(aok_a), .data_ok_o(dok_a),
        .rdata_o(rd_a), .err_o(err_a));

    data_sram_responder #(.ADDR_W(10), .LATENCY(0)) u_b (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req_b), .wr_i(wr_b), .size_i(size_b),
        .addr_i(addr_b), .wdata_i(wdata_b), .addr_ok_o(aok_b), .data_ok_o(dok_b),
        .rdata_o(rd_b), .err_o(err_b));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && dok_a) begin
            if (qa.size() == 0) chk("a_unexpected_data_ok", 32'd1, 32'd0);
            else begin
                e = qa.pop_front();
                chk("a_err", {31'd0, err_a}, {31'd0, e.err});
                if (e.chk) chk("a_rdata", rd_a, e.rd);
            end
        end
        if (rst_n && dok_b) begin
            if (qb.size() == 0) chk("b_unexpected_data_ok", 32'd1, 32'd0);
            else begin
                e = qb.pop_front();
                chk("b_err", {31'd0, err_b}, {31'd0, e.err});
                if (e.chk) chk("b_rdata", rd_b, e.rd);
            end
        end
    end

    // Called just after a negedge; returns on the negedge where data_ok is seen.
    task automatic xact(input bit b, input vec_t v);
        int n;
        exp_t e;
        e = '{v.rd, v.err, v.chk};
        if (b) begin
            req_b = 1'b1; wr_b = v.wr; size_b = v.size; addr_b = v.addr; wdata_b = v.wdata;
        end else begin
            req_a = 1'b1; wr_a = v.wr; size_a = v.size; addr_a = v.addr; wdata_a = v.wdata;
        end
        n = 0;
        while (!(b ? aok_b : aok_a) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("addr_ok_wait", {31'd0, b ? aok_b : aok_a}, 32'd1);
        if (b) qb.push_back(e);
        else qa.push_back(e);
        @(posedge clk);
        #1;
        if (b) req_b = 1'b0;
        else req_a = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(b ? dok_b : dok_a) && n < 20);
        chk(b ? "b_latency" : "a_latency", n, b ? 32'd1 : 32'd3);
    endtask

    initial begin
        int n;
        tbl[0]  = '{1'b1, 2'd2, 32'h10,   32'hDEADBEEF, 32'h0,        1'b0, 1'b0};
        tbl[1]  = '{1'b0, 2'd2, 32'h10,   32'h0,        32'hDEADBEEF, 1'b0, 1'b1};
        tbl[2]  = '{1'b1, 2'd2, 32'h10,   32'h11223344, 32'h0,        1'b0, 1'b0};
        tbl[3]  = '{1'b1, 2'd0, 32'h13,   32'hAA000000, 32'h0,        1'b0, 1'b0};
        tbl[4]  = '{1'b0, 2'd2, 32'h10,   32'h0,        32'hAA223344, 1'b0, 1'b1};
        tbl[5]  = '{1'b1, 2'd1, 32'h12,   32'h55660000, 32'h0,        1'b0, 1'b0};
        tbl[6]  = '{1'b0, 2'd2, 32'h10,   32'h0,        32'h55663344, 1'b0, 1'b1};
        tbl[7]  = '{1'b1, 2'd2, 32'h14,   32'h01020304, 32'h0,        1'b0, 1'b0};
        tbl[8]  = '{1'b1, 2'd2, 32'h16,   32'hFFFFFFFF, 32'h0,        1'b1, 1'b0};
        tbl[9]  = '{1'b0, 2'd2, 32'h14,   32'h0,        32'h01020304, 1'b0, 1'b1};
        tbl[10] = '{1'b0, 2'd3, 32'h14,   32'h0,        32'h0,        1'b1, 1'b1};
        tbl[11] = '{1'b1, 2'd2, 32'h1010, 32'hCAFEF00D, 32'h0,        1'b0, 1'b0};
        tbl[12] = '{1'b0, 2'd2, 32'h10,   32'h0,        32'hCAFEF00D, 1'b0, 1'b1};
        tbl[13] = '{1'b0, 2'd1, 32'h11,   32'h0,        32'h0,        1'b1, 1'b1};
        tbl[14] = '{1'b1, 2'd2, 32'h20,   32'h12345678, 32'h0,        1'b0, 1'b0};
        tbl[15] = '{1'b0, 2'd0, 32'h13,   32'h0,        32'hCAFEF00D, 1'b0, 1'b1};

        repeat (3) @(negedge clk);
        chk("rst_addr_ok", {31'd0, aok_a}, 32'd1);
        chk("rst_data_ok", {31'd0, dok_a}, 32'd0);
        chk("rst_rdata", rd_a, 32'd0);
        chk("rst_err", {31'd0, err_a}, 32'd0);
        chk("rst_b_addr_ok", {31'd0, aok_b}, 32'd1);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 16; i++) xact(1'b0, tbl[i]);

        // Reset during WAIT of a write to 0x20 drops it entirely.
        req_a = 1'b1; wr_a = 1'b1; size_a = 2'd2; addr_a = 32'h20; wdata_a = 32'hBAD0BAD0;
        @(posedge clk);
        #1;
        req_a = 1'b0;
        chk("mid_wait_addr_ok", {31'd0, aok_a}, 32'd0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_addr_ok", {31'd0, aok_a}, 32'd1);
        rst_n = 1'b1;
        n = 0;
        repeat (6) begin
            @(negedge clk);
            if (dok_a) n++;
        end
        chk("mid_rst_no_data_ok", n, 32'd0);
        xact(1'b0, '{1'b0, 2'd2, 32'h20, 32'h0, 32'h12345678, 1'b0, 1'b1});

        // Back-to-back reads on the zero-latency instance.
        xact(1'b1, '{1'b1, 2'd2, 32'h0, 32'hA0A0A0A0, 32'h0, 1'b0, 1'b0});
        xact(1'b1, '{1'b1, 2'd2, 32'h4, 32'hB1B1B1B1, 32'h0, 1'b0, 1'b0});
        xact(1'b1, '{1'b1, 2'd2, 32'h8, 32'hC2C2C2C2, 32'h0, 1'b0, 1'b0});
        @(negedge clk);
        req_b = 1'b1; wr_b = 1'b0; size_b = 2'd2;
        for (int k = 0; k < 3; k++) begin
            addr_b = 32'(4 * k);
            chk("b2b_addr_ok_pre", {31'd0, aok_b}, 32'd1);
            qb.push_back('{k == 0 ? 32'hA0A0A0A0 : k == 1 ? 32'hB1B1B1B1 : 32'hC2C2C2C2, 1'b0, 1'b1});
            @(posedge clk);
            #1;
            if (k == 2) req_b = 1'b0;
            @(negedge clk);
            chk("b2b_data_ok", {31'd0, dok_b}, 32'd1);
            chk("b2b_addr_ok", {31'd0, aok_b}, 32'd1);
        end
        @(negedge clk);
        chk("b2b_data_ok_end", {31'd0, dok_b}, 32'd0);

        repeat (3) @(negedge clk);
        chk("qa_drained", qa.size(), 32'd0);
        chk("qb_drained", qb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
